// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
//   Bundle between the core pipeline and the hazard controller.
//   master : pipeline side, drives decode/execute status, receives enables.
//   slave  : hazard controller, reads status, drives enables and counters.
//
// Handshake semantics: id_valid qualifies id_opc/id_rs1/id_rs2 in the same
// cycle (fields are don't-care while id_valid=0); ex_load qualifies ex_rd;
// ex_resolve is a single-cycle pulse that only has meaning while the
// controller waits for a control transfer; ext_stall is a level that freezes
// the whole pipeline for as long as it is high. There is no backpressure
// toward the pipeline other than the enables themselves.
interface pipe_hazard_ctrl_if;
  logic        ext_stall;
  logic        id_valid;
  logic [6:0]  id_opc;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        ex_load;
  logic [4:0]  ex_rd;
  logic        ex_resolve;

  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        halt;
  logic        ct_timeout;
  logic [15:0] stall_cycles;
  logic [15:0] flush_cycles;

  modport master (
    output ext_stall, id_valid, id_opc, id_rs1, id_rs2, ex_load, ex_rd, ex_resolve,
    input  pc_en, ifid_en, idex_en, ifid_flush, idex_bubble, halt, ct_timeout,
           stall_cycles, flush_cycles
  );

  modport slave (
    input  ext_stall, id_valid, id_opc, id_rs1, id_rs2, ex_load, ex_rd, ex_resolve,
    output pc_en, ifid_en, idex_en, ifid_flush, idex_bubble, halt, ct_timeout,
           stall_cycles, flush_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Pipeline hazard controller: load-use stalls, control-transfer flush and
//   wait, halt, external memory stall, optional performance counters.
//
// Parameters
//   LOAD_STALL_CYCLES  total stall cycles per load-use hazard (1..3)
//   MAX_CT_WAIT        control-transfer wait cycles before ct_timeout (2..255)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   bus        pipe_hazard_ctrl_if.slave (status in, enables/counters out)
//   dbg_state  current FSM state: 0 RUN, 1 LD_STALL, 2 CT_WAIT, 3 HALT
//
// Build option
//   PIPE_HAZARD_CTRL_PERF_EN  when defined, stall_cycles/flush_cycles count;
//                             otherwise both are tied to zero.
//
// Enables and flush/bubble controls are combinational from the registered
// state and the current-cycle inputs, so a hazard is acted on in the same
// cycle it is seen. All outputs read as idle while rst is high.
module pipe_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MAX_CT_WAIT       = 8
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_CT_WAIT  = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  // Cycles still to spend in LD_STALL after the first stall cycle in RUN.
  localparam logic [1:0] LD_EXTRA = 2'(LOAD_STALL_CYCLES - 1);
  localparam logic [7:0] CT_LIMIT = 8'(MAX_CT_WAIT);

  state_t     state_q, state_d;
  logic [1:0] ld_cnt_q, ld_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       ct_timeout_q, ct_timeout_d;

  logic pc_en_c, ifid_en_c, idex_en_c, ifid_flush_c, idex_bubble_c;
  logic count_stall, count_flush;

  // ---------------------------------------------------------------- decode
  logic is_ct_opc, is_halt_opc, lu_hazard;

  assign is_ct_opc   = (bus.id_opc == 7'b1101111) ||   // JAL
                       (bus.id_opc == 7'b1100111) ||   // JALR
                       (bus.id_opc == 7'b1100011);     // BRANCH
  assign is_halt_opc = (bus.id_opc == 7'b0000000);

  // x0 is never a real destination, so a load to x0 cannot create a hazard.
  assign lu_hazard = bus.id_valid && bus.ex_load && (bus.ex_rd != 5'd0) &&
                     ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));

  // ------------------------------------------------------- next state/outs
  always_comb begin
    state_d       = state_q;
    ld_cnt_d      = ld_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    ct_timeout_d  = ct_timeout_q;
    pc_en_c       = 1'b0;
    ifid_en_c     = 1'b0;
    idex_en_c     = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    count_stall   = 1'b0;
    count_flush   = 1'b0;

    // HALT holds everything off; ext_stall freezes every other state,
    // including any pending ex_resolve.
    if (state_q != ST_HALT && !bus.ext_stall) begin
      case (state_q)
        ST_RUN: begin
          pc_en_c   = 1'b1;
          ifid_en_c = 1'b1;
          idex_en_c = 1'b1;
          if (bus.id_valid && is_halt_opc) begin
            pc_en_c       = 1'b0;
            ifid_en_c     = 1'b0;
            idex_bubble_c = 1'b1;
            state_d       = ST_HALT;
          end else if (lu_hazard) begin
            // First stall cycle happens here in RUN.
            pc_en_c       = 1'b0;
            ifid_en_c     = 1'b0;
            idex_bubble_c = 1'b1;
            count_stall   = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d  = ST_LD_STALL;
              ld_cnt_d = LD_EXTRA;
            end
          end else if (bus.id_valid && is_ct_opc) begin
            // The CT itself moves on into ID-EX; the wrong-path fetch is killed.
            pc_en_c      = 1'b0;
            ifid_flush_c = 1'b1;
            count_flush  = 1'b1;
            state_d      = ST_CT_WAIT;
            wait_cnt_d   = 8'd0;
          end
        end

        ST_LD_STALL: begin
          idex_en_c     = 1'b1;
          idex_bubble_c = 1'b1;
          count_stall   = 1'b1;
          ld_cnt_d      = ld_cnt_q - 2'd1;
          if (ld_cnt_q == 2'd1) begin
            state_d = ST_RUN;
          end
        end

        ST_CT_WAIT: begin
          ifid_en_c     = 1'b1;
          idex_en_c     = 1'b1;
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
          count_flush   = 1'b1;
          if (bus.ex_resolve) begin
            // PC loads the resolved target this cycle.
            pc_en_c = 1'b1;
            state_d = ST_RUN;
          end else begin
            if (wait_cnt_q != 8'hFF) begin
              wait_cnt_d = wait_cnt_q + 8'd1;
            end
            if (wait_cnt_d == CT_LIMIT) begin
              ct_timeout_d = 1'b1;
            end
          end
        end

        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      ld_cnt_q     <= 2'd0;
      wait_cnt_q   <= 8'd0;
      ct_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_cnt_q     <= ld_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      ct_timeout_q <= ct_timeout_d;
    end
  end

  // ----------------------------------------------------- perf counters
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  // count_* are only raised on non-stalled, non-reset cycles, so ext_stall
  // cycles are excluded by construction.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (count_stall && stall_cnt_q != 16'hFFFF) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (count_flush && flush_cnt_q != 16'hFFFF) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign bus.stall_cycles = rst ? 16'd0 : stall_cnt_q;
  assign bus.flush_cycles = rst ? 16'd0 : flush_cnt_q;
`else
  logic unused_perf;
  assign unused_perf      = count_stall ^ count_flush;
  assign bus.stall_cycles = 16'd0;
  assign bus.flush_cycles = 16'd0;
`endif

  // ------------------------------------------------------------- outputs
  assign bus.pc_en       = !rst && pc_en_c;
  assign bus.ifid_en     = !rst && ifid_en_c;
  assign bus.idex_en     = !rst && idex_en_c;
  assign bus.ifid_flush  = !rst && ifid_flush_c;
  assign bus.idex_bubble = !rst && idex_bubble_c;
  assign bus.halt        = !rst && (state_q == ST_HALT);
  assign bus.ct_timeout  = !rst && ct_timeout_q;
  assign dbg_state       = rst ? ST_RUN : state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Two controllers share one stimulus stream: instance A with
//   LOAD_STALL_CYCLES=3 / MAX_CT_WAIT=8, instance B with 1 / 4. A behavioural
//   model per instance predicts every output each cycle; predictions go
//   through an expected queue and are compared field by field.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int W = 41;

  // ------------------------------------------------------ clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus_a ();
  pipe_hazard_ctrl_if bus_b ();
  logic [1:0] dbg_a, dbg_b;

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MAX_CT_WAIT(8)) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .dbg_state(dbg_a)
  );
  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MAX_CT_WAIT(4)) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .dbg_state(dbg_b)
  );

  // ------------------------------------------------------ stimulus state
  logic       s_ext, s_valid, s_load, s_res;
  logic [6:0] s_opc;
  logic [4:0] s_rs1, s_rs2, s_rd;

  // ------------------------------------------------------ model
  typedef enum {M_RUN, M_LOAD, M_WAIT, M_HALT} mode_t;
  mode_t mode [2];
  int    stall_left [2];
  int    waited [2];
  bit    tmo [2];
  int    n_stall [2];
  int    n_flush [2];
  int    lsc [2]  = '{3, 1};
  int    maxw [2] = '{8, 4};
  int    halt_age;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] mode_code(input mode_t m);
    case (m)
      M_RUN:  return 2'd0;
      M_LOAD: return 2'd1;
      M_WAIT: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Predict this cycle's outputs for instance i and advance the model.
  task automatic model_step(input int i);
    bit pc, ifid, idex, fl, bub, hlt, to_o, lu, ct, hop;
    logic [1:0]  st;
    logic [15:0] sc, fc;
    pc = 0; ifid = 0; idex = 0; fl = 0; bub = 0;
    lu  = s_valid && s_load && (s_rd != 0) && (s_rd == s_rs1 || s_rd == s_rs2);
    ct  = s_valid && (s_opc == 7'b1101111 || s_opc == 7'b1100111 || s_opc == 7'b1100011);
    hop = s_valid && (s_opc == 7'b0000000);
    if (rst) begin
      st = 2'd0; hlt = 0; to_o = 0; sc = 0; fc = 0;
      mode[i] = M_RUN; stall_left[i] = 0; waited[i] = 0; tmo[i] = 0;
      n_stall[i] = 0; n_flush[i] = 0;
    end else begin
      st   = mode_code(mode[i]);
      hlt  = (mode[i] == M_HALT);
      to_o = tmo[i];
      sc   = PERF ? 16'(n_stall[i]) : 16'd0;
      fc   = PERF ? 16'(n_flush[i]) : 16'd0;
      if (mode[i] != M_HALT && !s_ext) begin
        case (mode[i])
          M_RUN: begin
            pc = 1; ifid = 1; idex = 1;
            if (hop) begin
              pc = 0; ifid = 0; bub = 1; mode[i] = M_HALT;
            end else if (lu) begin
              pc = 0; ifid = 0; bub = 1; n_stall[i]++;
              stall_left[i] = lsc[i] - 1;
              if (stall_left[i] > 0) mode[i] = M_LOAD;
            end else if (ct) begin
              pc = 0; fl = 1; n_flush[i]++; mode[i] = M_WAIT; waited[i] = 0;
            end
          end
          M_LOAD: begin
            idex = 1; bub = 1; n_stall[i]++;
            stall_left[i]--;
            if (stall_left[i] == 0) mode[i] = M_RUN;
          end
          default: begin  // M_WAIT
            ifid = 1; idex = 1; fl = 1; bub = 1; n_flush[i]++;
            if (s_res) begin
              pc = 1; mode[i] = M_RUN;
            end else begin
              if (waited[i] < 255) waited[i]++;
              if (waited[i] == maxw[i]) tmo[i] = 1;
            end
          end
        endcase
      end
      if (n_stall[i] > 65535) n_stall[i] = 65535;
      if (n_flush[i] > 65535) n_flush[i] = 65535;
    end
    exp_q.push_back({st, sc, fc, pc, ifid, idex, fl, bub, hlt, to_o});
  endtask

  function automatic logic [W-1:0] actual(input int i);
    if (i == 0)
      return {dbg_a, bus_a.stall_cycles, bus_a.flush_cycles, bus_a.pc_en, bus_a.ifid_en,
              bus_a.idex_en, bus_a.ifid_flush, bus_a.idex_bubble, bus_a.halt, bus_a.ct_timeout};
    return {dbg_b, bus_b.stall_cycles, bus_b.flush_cycles, bus_b.pc_en, bus_b.ifid_en,
            bus_b.idex_en, bus_b.ifid_flush, bus_b.idex_bubble, bus_b.halt, bus_b.ct_timeout};
  endfunction

  task automatic compare(input int i);
    logic [W-1:0] e, a;
    string n;
    n = (i == 0) ? "A" : "B";
    e = exp_q.pop_front();
    a = actual(i);
    chk({n, ".state"},        32'(a[40:39]), 32'(e[40:39]));
    chk({n, ".stall_cycles"}, 32'(a[38:23]), 32'(e[38:23]));
    chk({n, ".flush_cycles"}, 32'(a[22:7]),  32'(e[22:7]));
    chk({n, ".pc_en"},        32'(a[6]),     32'(e[6]));
    chk({n, ".ifid_en"},      32'(a[5]),     32'(e[5]));
    chk({n, ".idex_en"},      32'(a[4]),     32'(e[4]));
    chk({n, ".ifid_flush"},   32'(a[3]),     32'(e[3]));
    chk({n, ".idex_bubble"},  32'(a[2]),     32'(e[2]));
    chk({n, ".halt"},         32'(a[1]),     32'(e[1]));
    chk({n, ".ct_timeout"},   32'(a[0]),     32'(e[0]));
  endtask

  // ------------------------------------------------------ driver tasks
  task automatic drive(input bit r, input bit e, input bit v, input logic [6:0] opc,
                       input logic [4:0] rs1, input logic [4:0] rs2, input bit ld,
                       input logic [4:0] rd, input bit res);
    @(negedge clk);
    rst = r;
    s_ext = e; s_valid = v; s_opc = opc; s_rs1 = rs1; s_rs2 = rs2;
    s_load = ld; s_rd = rd; s_res = res;
    bus_a.ext_stall = e; bus_a.id_valid = v; bus_a.id_opc = opc; bus_a.id_rs1 = rs1;
    bus_a.id_rs2 = rs2; bus_a.ex_load = ld; bus_a.ex_rd = rd; bus_a.ex_resolve = res;
    bus_b.ext_stall = e; bus_b.id_valid = v; bus_b.id_opc = opc; bus_b.id_rs1 = rs1;
    bus_b.id_rs2 = rs2; bus_b.ex_load = ld; bus_b.ex_rd = rd; bus_b.ex_resolve = res;
    #2;
    model_step(0);
    model_step(1);
    compare(0);
    compare(1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 7'b0110011, 5'd0, 5'd0, 0, 5'd0, 0);
  endtask

  task automatic reset_cycles(input int n);
    for (int k = 0; k < n; k++) drive(1, 0, 0, 7'b0110011, 5'd0, 5'd0, 0, 5'd0, 0);
  endtask

  task automatic rand_cycle();
    bit r, e, v, ld, res;
    logic [6:0] opc;
    int k;
    if (mode[0] == M_HALT || mode[1] == M_HALT) halt_age++;
    else halt_age = 0;
    r = (halt_age > 12) || ($urandom_range(0, 299) == 0);
    if (r) halt_age = 0;
    e   = ($urandom_range(0, 9) == 0);
    v   = ($urandom_range(0, 9) != 0);
    ld  = ($urandom_range(0, 9) < 4);
    res = ($urandom_range(0, 9) < 2);
    k = $urandom_range(0, 79);
    if (k == 0)       opc = 7'b0000000;
    else if (k < 6)   opc = 7'b1101111;
    else if (k < 11)  opc = 7'b1100111;
    else if (k < 18)  opc = 7'b1100011;
    else if (k < 30)  opc = 7'b0000011;
    else              opc = 7'b0110011;
    drive(r, e, v, opc, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), ld,
          5'($urandom_range(0, 3)), res);
  endtask

  // ------------------------------------------------------ main sequence
  initial begin
    halt_age = 0;
    reset_cycles(3);
    idle(2);

    // Load-use on rs2, then a load to x0 that must not stall.
    drive(0, 0, 1, 7'b0110011, 5'd1, 5'd5, 1, 5'd5, 0);
    idle(4);
    drive(0, 0, 1, 7'b0110011, 5'd0, 5'd0, 1, 5'd0, 0);
    idle(2);

    // Branch resolved on the third cycle after the branch.
    drive(0, 0, 1, 7'b1100011, 5'd1, 5'd2, 0, 5'd0, 0);
    idle(2);
    drive(0, 0, 0, 7'b0110011, 5'd0, 5'd0, 0, 5'd0, 1);
    idle(2);

    // Unresolved JAL runs into the timeout on both instances.
    drive(0, 0, 1, 7'b1101111, 5'd0, 5'd0, 0, 5'd0, 0);
    idle(11);
    drive(0, 0, 0, 7'b0110011, 5'd0, 5'd0, 0, 5'd0, 1);
    idle(1);

    // ext_stall inside CT_WAIT swallows a resolve pulse.
    reset_cycles(1);
    drive(0, 0, 1, 7'b1100111, 5'd0, 5'd0, 0, 5'd0, 0);
    idle(1);
    drive(0, 1, 0, 7'b0110011, 5'd0, 5'd0, 0, 5'd0, 1);
    drive(0, 1, 0, 7'b0110011, 5'd0, 5'd0, 0, 5'd0, 1);
    idle(1);
    drive(0, 0, 0, 7'b0110011, 5'd0, 5'd0, 0, 5'd0, 1);
    idle(1);

    // Halt, then CT/LU traffic that must be ignored, then reset.
    drive(0, 0, 1, 7'b0000000, 5'd0, 5'd0, 0, 5'd0, 0);
    for (int k = 0; k < 10; k++)
      drive(0, (k == 4), 1, (k % 2) ? 7'b1100011 : 7'b0110011, 5'd3, 5'd2, 1, 5'd3, (k == 6));
    reset_cycles(2);
    idle(2);

    for (int k = 0; k < 4000; k++) rand_cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
